// File: rtl/alu_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared types and helpers for the ALU operand-entry sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_pkg;

    // Default ALU opcode width
    localparam int OP_W_DEFAULT = 4;

    // Operand-entry sequence: load A, load B, select op, show result
    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_SHOW = 2'd3
    } state_t;

    // One-hot front-panel indicator for a given state
    function automatic logic [3:0] state_to_led(input state_t s);
        logic [3:0] led;
        led = 4'b0001;
        case (s)
            S_A:     led = 4'b0001;
            S_B:     led = 4'b0010;
            S_OP:    led = 4'b0100;
            S_SHOW:  led = 4'b1000;
            default: led = 4'b0001;
        endcase
        return led;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_ctrl_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchronizer, stability-count debouncer and
//               rising-edge pulse generator for one bouncing push-button.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_pulse;

    // Bring the asynchronous button level into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it differs for DEBOUNCE_CYCLES cycles in a
    // row; the press pulse is raised on the same edge the level goes high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_pulse <= r_sync2;
            end else begin
                r_cnt <= r_cnt + C_CNT_ONE;
            end
        end
    end

    assign btn_level = r_level;
    assign btn_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_ctrl
// Description : Operand-entry sequencer for the 8-bit ALU board. Debounces
//               the "next" and "clear" buttons and steps load A -> load B ->
//               select op -> show result, driving the operand register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int OP_W            = alu_ctrl_pkg::OP_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            btn_next,
    input  logic            btn_clr,
    input  logic [OP_W-1:0] sw_op,
    output logic            load_en,
    output logic            load_sel,
    output logic            reg_clr,
    output logic [OP_W-1:0] op_code,
    output logic            op_valid,
    output logic [3:0]      state_led
);

    import alu_ctrl_pkg::*;

    logic            w_next_p;
    logic            w_clr_p;

    state_t          r_state;
    logic            r_load_en;
    logic            r_load_sel;
    logic            r_reg_clr;
    logic [OP_W-1:0] r_op_code;
    logic            r_op_valid;
    logic [3:0]      r_state_led;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_next_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_next),
        .btn_level (),
        .btn_pulse (w_next_p)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clr_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_clr),
        .btn_level (),
        .btn_pulse (w_clr_p)
    );

    // Sequencer: clear overrides next; strobes are single-cycle by default-low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_A;
            r_load_en   <= 1'b0;
            r_load_sel  <= 1'b0;
            r_reg_clr   <= 1'b0;
            r_op_code   <= '0;
            r_op_valid  <= 1'b0;
            r_state_led <= state_to_led(S_A);
        end else begin
            r_load_en <= 1'b0;
            r_reg_clr <= 1'b0;
            if (w_clr_p) begin
                r_state     <= S_A;
                r_reg_clr   <= 1'b1;
                r_op_code   <= '0;
                r_op_valid  <= 1'b0;
                r_state_led <= state_to_led(S_A);
            end else begin
                case (r_state)
                    S_A: begin
                        if (w_next_p) begin
                            r_load_en   <= 1'b1;
                            r_load_sel  <= 1'b0;
                            r_state     <= S_B;
                            r_state_led <= state_to_led(S_B);
                        end
                    end
                    S_B: begin
                        if (w_next_p) begin
                            r_load_en   <= 1'b1;
                            r_load_sel  <= 1'b1;
                            r_state     <= S_OP;
                            r_state_led <= state_to_led(S_OP);
                        end
                    end
                    S_OP: begin
                        if (w_next_p) begin
                            r_op_code   <= sw_op;
                            r_op_valid  <= 1'b1;
                            r_state     <= S_SHOW;
                            r_state_led <= state_to_led(S_SHOW);
                        end
                    end
                    S_SHOW: begin
                        if (w_next_p) begin
                            r_op_valid  <= 1'b0;
                            r_state     <= S_A;
                            r_state_led <= state_to_led(S_A);
                        end
                    end
                    default: begin
                        r_state     <= S_A;
                        r_state_led <= state_to_led(S_A);
                    end
                endcase
            end
        end
    end

    assign load_en   = r_load_en;
    assign load_sel  = r_load_sel;
    assign reg_clr   = r_reg_clr;
    assign op_code   = r_op_code;
    assign op_valid  = r_op_valid;
    assign state_led = r_state_led;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_ctrl
// Description : Self-checking bench for alu_seq_ctrl with a behavioural model
//               of button acceptance and the operand-entry sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_ctrl;

    localparam int DC   = 4;
    localparam int OPW  = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           btn_next = 1'b0;
    logic           btn_clr = 1'b0;
    logic [OPW-1:0] sw_op = '0;
    logic           load_en;
    logic           load_sel;
    logic           reg_clr;
    logic [OPW-1:0] op_code;
    logic           op_valid;
    logic [3:0]     state_led;

    alu_seq_ctrl #(
        .DEBOUNCE_CYCLES (DC),
        .OP_W            (OPW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_next  (btn_next),
        .btn_clr   (btn_clr),
        .sw_op     (sw_op),
        .load_en   (load_en),
        .load_sel  (load_sel),
        .reg_clr   (reg_clr),
        .op_code   (op_code),
        .op_valid  (op_valid),
        .state_led (state_led)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cnt_load    = 0;
    int cnt_clr     = 0;

    // ---------------- behavioural reference model ----------------
    // Raw button samples taken at each active edge since reset.
    bit             nq[$];
    bit             cq[$];
    bit             m_nlev, m_clev, m_np, m_cp;
    int             m_state;           // 0=A 1=B 2=OP 3=SHOW
    bit             m_load_en, m_load_sel, m_reg_clr, m_op_valid;
    logic [OPW-1:0] m_op_code;

    // A button flips its accepted level once the DC samples seen through the
    // two-stage synchronizer all disagree with the current level.
    function automatic bit accepts(input bit q[$], input bit lev);
        for (int k = 0; k < DC; k++) begin
            int idx;
            bit s;
            idx = q.size() - 3 - k;
            s   = (idx >= 0) ? q[idx] : 1'b0;
            if (s == lev) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        nq.delete();
        cq.delete();
        m_nlev = 0; m_clev = 0; m_np = 0; m_cp = 0;
        m_state = 0;
        m_load_en = 0; m_load_sel = 0; m_reg_clr = 0; m_op_valid = 0;
        m_op_code = '0;
    endtask

    task automatic model_edge();
        m_load_en = 0;
        m_reg_clr = 0;
        if (m_cp) begin
            m_state    = 0;
            m_reg_clr  = 1;
            m_op_valid = 0;
            m_op_code  = '0;
        end else if (m_np) begin
            case (m_state)
                0: begin m_load_en = 1; m_load_sel = 0; m_state = 1; end
                1: begin m_load_en = 1; m_load_sel = 1; m_state = 2; end
                2: begin m_op_code = sw_op; m_op_valid = 1; m_state = 3; end
                default: begin m_op_valid = 0; m_state = 0; end
            endcase
        end
        nq.push_back(btn_next);
        cq.push_back(btn_clr);
        if (nq.size() > DC + 3) void'(nq.pop_front());
        if (cq.size() > DC + 3) void'(cq.pop_front());
        m_np = 0;
        m_cp = 0;
        if (accepts(nq, m_nlev)) begin m_nlev = !m_nlev; m_np = m_nlev; end
        if (accepts(cq, m_clev)) begin m_clev = !m_clev; m_cp = m_clev; end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("state_led", 32'(state_led), 32'(4'b0001 << m_state));
        chk("load_en",   32'(load_en),   32'(m_load_en));
        chk("reg_clr",   32'(reg_clr),   32'(m_reg_clr));
        chk("op_valid",  32'(op_valid),  32'(m_op_valid));
        chk("op_code",   32'(op_code),   32'(m_op_code));
        if (m_load_en) chk("load_sel", 32'(load_sel), 32'(m_load_sel));
    endtask

    // One clock: advance the model on the edge, compare just after it.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        if (load_en) cnt_load++;
        if (reg_clr) cnt_clr++;
        check_outputs();
    endtask

    task automatic press(input bit nx, input bit cl, input int hold, input int gap);
        btn_next = nx;
        btn_clr  = cl;
        for (int i = 0; i < hold; i++) tick();
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        for (int i = 0; i < gap; i++) tick();
    endtask

    logic [3:0] exp_led [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        int hit;
        int found;
        model_reset();

        // Reset held: outputs at reset values
        for (int i = 0; i < 3; i++) tick();
        chk("rst_led",   32'(state_led), 32'h1);
        chk("rst_loads", 32'({load_en, reg_clr, op_valid}), 32'h0);
        chk("rst_op",    32'(op_code), 32'h0);

        // Idle after release: no strobes
        rst_n = 1'b1;
        cnt_load = 0; cnt_clr = 0;
        for (int i = 0; i < 50; i++) tick();
        chk("idle_strobes", 32'(cnt_load + cnt_clr), 32'h0);

        // Full sequence with opcode 5
        sw_op = 4'h5;
        cnt_load = 0;
        for (int p = 0; p < 4; p++) begin
            press(1'b1, 1'b0, 20, 10);
            chk("seq_led", 32'(state_led), 32'(exp_led[p]));
            if (p == 2) begin
                chk("seq_opcode", 32'(op_code),  32'h5);
                chk("seq_valid",  32'(op_valid), 32'h1);
            end
        end
        chk("seq_valid_off", 32'(op_valid), 32'h0);
        chk("seq_loads",     32'(cnt_load), 32'h2);

        // Bounce rejection, then a clean hold in S_A
        sw_op = 4'hA;
        cnt_load = 0;
        for (int i = 0; i < 30; i++) begin
            btn_next = ((i / 2) % 2) == 1;
            tick();
        end
        chk("bounce_none", 32'(cnt_load), 32'h0);
        btn_next = 1'b1;
        hit = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (load_en && hit < 0) hit = i;
        end
        btn_next = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("bounce_one",   32'(cnt_load), 32'h1);
        chk("bounce_delay", 32'(hit),      32'h6);

        // Advance to S_OP, then clear
        press(1'b1, 1'b0, 10, 10);
        chk("pre_clr_led", 32'(state_led), 32'h4);
        cnt_clr = 0;
        press(1'b0, 1'b1, 10, 10);
        chk("clr_once",  32'(cnt_clr),   32'h1);
        chk("clr_led",   32'(state_led), 32'h1);
        chk("clr_op",    32'(op_code),   32'h0);
        chk("clr_valid", 32'(op_valid),  32'h0);

        // Simultaneous next+clr while in S_B
        press(1'b1, 1'b0, 10, 10);
        cnt_clr = 0; cnt_load = 0;
        press(1'b1, 1'b1, 10, 10);
        chk("both_clr",  32'(cnt_clr),   32'h1);
        chk("both_load", 32'(cnt_load),  32'h0);
        chk("both_led",  32'(state_led), 32'h1);

        // Randomized presses, bounces and opcode switching
        for (int r = 0; r < 40; r++) begin
            int kind;
            int hold;
            int gap;
            kind = $urandom_range(0, 9);
            hold = $urandom_range(1, 10);
            gap  = $urandom_range(0, 8);
            btn_next = (kind <= 6) || (kind == 8);
            btn_clr  = (kind >= 7) && (kind <= 8);
            for (int i = 0; i < hold; i++) begin
                sw_op = 4'($urandom);
                tick();
            end
            btn_next = 1'b0;
            btn_clr  = 1'b0;
            for (int i = 0; i < gap; i++) begin
                sw_op = 4'($urandom);
                tick();
            end
        end
        press(1'b0, 1'b0, 0, 10);

        // Reset asserted during an active load strobe
        btn_next = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (load_en) found = 1;
        end
        chk("rst_wait_load", 32'(found), 32'h1);
        rst_n = 1'b0;
        btn_next = 1'b0;
        #1;
        chk("rst_async_load", 32'(load_en),   32'h0);
        chk("rst_async_led",  32'(state_led), 32'h1);
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        cnt_load = 0; cnt_clr = 0;
        for (int i = 0; i < 20; i++) tick();
        chk("post_rst_quiet", 32'(cnt_load + cnt_clr), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Operand-entry sequencer for the 8-bit ALU board design. It debounces the front-panel "next" and "clear" buttons and steps a four-state FSM: load A, load B, select op, show result. It drives the one-cycle load strobe and the A/B select into the operand register bank, and latches the ALU opcode. It sits between the raw board buttons/switches and the operand registers plus ALU.

## Interface
- DEBOUNCE_CYCLES, 1_000_000: cycles a synchronized button level must stay stable before it is accepted (10 ms at 100 MHz); sims use 4.
- OP_W, 4: opcode width.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- btn_next  in  1  raw, asynchronous, bouncing "advance" button.
- btn_clr  in  1  raw, asynchronous, bouncing "clear" button.
- sw_op  in  OP_W  opcode switches; sampled only in S_OP.
- load_en  out  1  one-cycle load strobe to the operand registers.
- load_sel  out  1  0 = load A, 1 = load B; meaningful only while load_en=1.
- reg_clr  out  1  one-cycle pulse that clears the operand registers.
- op_code  out  OP_W  latched ALU opcode.
- op_valid  out  1  op_code is valid and the result may be displayed.
- state_led  out  4  one-hot state indicator: bit0 S_A, bit1 S_B, bit2 S_OP, bit3 S_SHOW.

## Operation
- Each button goes through its own btn_debounce instance:
  - 2-flop synchronizer.
  - Stability counter: resets whenever the synced level equals the debounced level.
  - When the synced level differs for DEBOUNCE_CYCLES consecutive cycles, the debounced level updates.
  - A rising edge of the debounced level produces a one-cycle pulse (next_p, clr_p).
  - Releases never produce a pulse.
- FSM states S_A → S_B → S_OP → S_SHOW → S_A.
  - S_A on next_p: load_en=1, load_sel=0; go to S_B.
  - S_B on next_p: load_en=1, load_sel=1; go to S_OP.
  - S_OP on next_p: op_code←sw_op, op_valid←1; go to S_SHOW.
  - S_SHOW on next_p: op_valid←0; go to S_A. op_code holds its value.
- clr_p in any state: go to S_A, reg_clr=1 for one cycle, op_valid←0, op_code←0, load_en=0.
- If clr_p and next_p arrive in the same cycle, clr_p wins and next_p is dropped.
- sw_op changes outside S_OP have no effect.
- No other state transitions exist. An unreachable state encoding recovers to S_A.

## Timing
- Reset values: state S_A, state_led=4'b0001, load_en=0, load_sel=0, reg_clr=0, op_code=0, op_valid=0, debounced levels 0, counters 0.
- Button latency: a clean press held from cycle 0 gives a pulse in cycle 2+DEBOUNCE_CYCLES (2 sync + count + edge register).
- All outputs are registered. load_en, load_sel, reg_clr, op_valid, op_code and state_led update on the same edge that consumes the pulse, i.e. one cycle after the pulse.
- load_en and reg_clr are high for exactly one cycle per accepted pulse.
- Bounces shorter than DEBOUNCE_CYCLES produce no pulse. A press held indefinitely produces exactly one pulse.
- rst_n assertion mid-sequence, including during an active load_en cycle, forces reset values immediately. No strobe is emitted after deassertion until a new press is accepted.
- The rst_n deassertion edge is synchronized by the top level; the block needs no extra reset stretching.

## Structure
- Package alu_ctrl_pkg contains:
  - state typedef (enum logic [1:0]: S_A, S_B, S_OP, S_SHOW);
  - OP_W default constant;
  - function mapping state to one-hot state_led.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_raw, btn_level, btn_pulse), instantiated twice.
- Counter width is $clog2(DEBOUNCE_CYCLES+1).

## Test plan
(All scenarios use DEBOUNCE_CYCLES=4.)
- Reset: hold rst_n=0 → all outputs at reset values and state_led=4'b0001. Release rst_n, no buttons pressed for 50 cycles → no strobes.
- Full sequence: press next 4 times, each held 20 cycles with gaps, sw_op=4'h5 during S_OP →
  - load_en pulses twice, with load_sel 0 then 1;
  - op_code=4'h5 and op_valid=1 in S_SHOW;
  - op_valid=0 back in S_A;
  - state_led steps 0001→0010→0100→1000→0001.
- Bounce rejection: btn_next toggles every 2 cycles for 30 cycles, then held high 20 cycles → exactly one load_en pulse, 6 cycles after the hold starts.
- Clear: from S_OP press clr → reg_clr is a single-cycle pulse, state S_A, op_code=0, op_valid=0.
- Simultaneous press: press next and clr in the same cycle while in S_B → reg_clr pulses, load_en stays 0, state S_A.
- Reset mid-operation: assert rst_n=0 in the cycle load_en=1 → load_en drops immediately and state_led=4'b0001.
